// File: rtl/sdram_arb_pkg.sv
// Shared types and helpers for the SDRAM Avalon-MM read/write arbiter:
// FSM state encoding, grant codes and the counter width helper.
package sdram_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_GRANT_RD = 2'b01,
        ST_GRANT_WR = 2'b10
    } arb_state_e;

    localparam logic [1:0] GRANT_IDLE_C = 2'b00;
    localparam logic [1:0] GRANT_RD_C   = 2'b01;
    localparam logic [1:0] GRANT_WR_C   = 2'b10;

    // Bits needed to hold the values 0..max_val (at least one bit).
    function automatic int cnt_width(input int max_val);
        if (max_val < 2) begin
            return 1;
        end else begin
            return $clog2(max_val + 1);
        end
    endfunction

endpackage

// File: rtl/sdram_avalon_arbiter_if.sv
// Avalon-MM bundle around the arbiter: read master, write master and SDRAM slave.
// Signal names are seen from the arbiter; the slave modport is the arbiter side.
interface sdram_avalon_arbiter_if #(
    parameter int ADDR_W = 25,
    parameter int DATA_W = 16
);
    logic              iRD_REQ;
    logic [ADDR_W-1:0] iRD_ADDR;
    logic              oRD_WAIT;
    logic [DATA_W-1:0] oRD_DATA;
    logic              oRD_DATAVALID;
    logic              iWR_REQ;
    logic [ADDR_W-1:0] iWR_ADDR;
    logic [DATA_W-1:0] iWR_DATA;
    logic              oWR_WAIT;
    logic [ADDR_W-1:0] oSDRAM_ADDR;
    logic              oSDRAM_RD;
    logic              oSDRAM_WR;
    logic [DATA_W-1:0] oSDRAM_WRDATA;
    logic              iSDRAM_WAIT;
    logic [DATA_W-1:0] iSDRAM_RDDATA;
    logic              iSDRAM_RDDATAVALID;

    modport slave (
        input  iRD_REQ, iRD_ADDR, iWR_REQ, iWR_ADDR, iWR_DATA,
               iSDRAM_WAIT, iSDRAM_RDDATA, iSDRAM_RDDATAVALID,
        output oRD_WAIT, oRD_DATA, oRD_DATAVALID, oWR_WAIT,
               oSDRAM_ADDR, oSDRAM_RD, oSDRAM_WR, oSDRAM_WRDATA
    );

    modport master (
        output iRD_REQ, iRD_ADDR, iWR_REQ, iWR_ADDR, iWR_DATA,
               iSDRAM_WAIT, iSDRAM_RDDATA, iSDRAM_RDDATAVALID,
        input  oRD_WAIT, oRD_DATA, oRD_DATAVALID, oWR_WAIT,
               oSDRAM_ADDR, oSDRAM_RD, oSDRAM_WR, oSDRAM_WRDATA
    );
endinterface

// File: rtl/sdram_arb_pending_cnt.sv
// Outstanding-read tracker: up/down counter bounded at MAX_PENDING with a
// full flag and a sticky error when a return arrives with nothing pending.
module sdram_arb_pending_cnt
    import sdram_arb_pkg::*;
#(
    parameter  int MAX_PENDING = 7,
    localparam int CNT_W       = cnt_width(MAX_PENDING)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    input  logic             dec_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             full_o,
    output logic             err_o
);
    localparam logic [CNT_W-1:0] MAX_C  = CNT_W'(MAX_PENDING);
    localparam logic [CNT_W-1:0] ZERO_C = CNT_W'(0);
    localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    // Next count and sticky underflow flag.
    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if (inc_i && !dec_i && (cnt_q != MAX_C)) begin
            cnt_d = cnt_q + ONE_C;
        end else if (dec_i && !inc_i && (cnt_q != ZERO_C)) begin
            cnt_d = cnt_q - ONE_C;
        end else begin
            cnt_d = cnt_q;
        end
        if (dec_i && (cnt_q == ZERO_C)) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end
    end

    // Counter and error registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= ZERO_C;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign full_o = (cnt_q == MAX_C);
    assign err_o  = err_q;

endmodule

// File: rtl/sdram_avalon_arbiter.sv
// Run-time arbiter sharing one SDRAM Avalon-MM slave between the VGA read
// master (priority) and the image write master (bounded burst share).
module sdram_avalon_arbiter
    import sdram_arb_pkg::*;
#(
    parameter  int ADDR_W       = 25,
    parameter  int DATA_W       = 16,
    parameter  int MAX_RD_BURST = 8,
    parameter  int MAX_WR_BURST = 4,
    parameter  int MAX_PENDING  = 7,
    localparam int PEND_W       = cnt_width(MAX_PENDING)
) (
    input  logic                  iCLK,
    input  logic                  iRST,
    sdram_avalon_arbiter_if.slave bus,
    output logic [1:0]            oGRANT,
    output logic [PEND_W-1:0]     oPENDING,
    output logic                  oERROR
);
    localparam int RD_CNT_W = cnt_width(MAX_RD_BURST - 1);
    localparam int WR_CNT_W = cnt_width(MAX_WR_BURST - 1);
    localparam logic [RD_CNT_W-1:0] RD_LAST_C = RD_CNT_W'(MAX_RD_BURST - 1);
    localparam logic [WR_CNT_W-1:0] WR_LAST_C = WR_CNT_W'(MAX_WR_BURST - 1);

    arb_state_e          state_q, state_d;
    logic [RD_CNT_W-1:0] rd_cnt_q, rd_cnt_d;
    logic [WR_CNT_W-1:0] wr_cnt_q, wr_cnt_d;
    logic                full_s;
    logic                rd_acc_s;
    logic                wr_acc_s;

    assign rd_acc_s = (state_q == ST_GRANT_RD) & bus.iRD_REQ & ~full_s & ~bus.iSDRAM_WAIT;
    assign wr_acc_s = (state_q == ST_GRANT_WR) & bus.iWR_REQ & ~bus.iSDRAM_WAIT;

    // State and burst-counter registers.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q  <= ST_IDLE;
            rd_cnt_q <= RD_CNT_W'(0);
            wr_cnt_q <= WR_CNT_W'(0);
        end else begin
            state_q  <= state_d;
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    // Next grant: a burst only yields on an accepted transfer, never mid-stall.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.iRD_REQ) begin
                    state_d = ST_GRANT_RD;
                end else if (bus.iWR_REQ) begin
                    state_d = ST_GRANT_WR;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GRANT_RD: begin
                if (!bus.iRD_REQ) begin
                    state_d = bus.iWR_REQ ? ST_GRANT_WR : ST_IDLE;
                end else if (rd_acc_s && (rd_cnt_q == RD_LAST_C) && bus.iWR_REQ) begin
                    state_d = ST_GRANT_WR;
                end else begin
                    state_d = ST_GRANT_RD;
                end
            end
            ST_GRANT_WR: begin
                if (!bus.iWR_REQ) begin
                    state_d = bus.iRD_REQ ? ST_GRANT_RD : ST_IDLE;
                end else if (wr_acc_s && (wr_cnt_q == WR_LAST_C) && bus.iRD_REQ) begin
                    state_d = ST_GRANT_RD;
                end else begin
                    state_d = ST_GRANT_WR;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Burst counters saturate at their last slot and restart on every grant change.
    always_comb begin
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        if (state_d != state_q) begin
            rd_cnt_d = RD_CNT_W'(0);
            wr_cnt_d = WR_CNT_W'(0);
        end else begin
            if (rd_acc_s && (rd_cnt_q != RD_LAST_C)) begin
                rd_cnt_d = rd_cnt_q + RD_CNT_W'(1);
            end else begin
                rd_cnt_d = rd_cnt_q;
            end
            if (wr_acc_s && (wr_cnt_q != WR_LAST_C)) begin
                wr_cnt_d = wr_cnt_q + WR_CNT_W'(1);
            end else begin
                wr_cnt_d = wr_cnt_q;
            end
        end
    end

    // Route the granted master onto the slave; the other master is held off.
    always_comb begin
        oGRANT            = GRANT_IDLE_C;
        bus.oSDRAM_RD     = 1'b0;
        bus.oSDRAM_WR     = 1'b0;
        bus.oSDRAM_ADDR   = {ADDR_W{1'b0}};
        bus.oSDRAM_WRDATA = {DATA_W{1'b0}};
        bus.oRD_WAIT      = 1'b1;
        bus.oWR_WAIT      = 1'b1;
        case (state_q)
            ST_GRANT_RD: begin
                oGRANT          = GRANT_RD_C;
                bus.oSDRAM_RD   = bus.iRD_REQ & ~full_s;
                bus.oSDRAM_ADDR = bus.iRD_ADDR;
                bus.oRD_WAIT    = bus.iSDRAM_WAIT | full_s;
            end
            ST_GRANT_WR: begin
                oGRANT            = GRANT_WR_C;
                bus.oSDRAM_WR     = bus.iWR_REQ;
                bus.oSDRAM_ADDR   = bus.iWR_ADDR;
                bus.oSDRAM_WRDATA = bus.iWR_DATA;
                bus.oWR_WAIT      = bus.iSDRAM_WAIT;
            end
            default: oGRANT = GRANT_IDLE_C;
        endcase
    end

    assign bus.oRD_DATA      = bus.iSDRAM_RDDATA;
    assign bus.oRD_DATAVALID = bus.iSDRAM_RDDATAVALID;

    sdram_arb_pending_cnt #(
        .MAX_PENDING (MAX_PENDING)
    ) u_pending (
        .clk_i  (iCLK),
        .rst_i  (iRST),
        .inc_i  (rd_acc_s),
        .dec_i  (bus.iSDRAM_RDDATAVALID),
        .cnt_o  (oPENDING),
        .full_o (full_s),
        .err_o  (oERROR)
    );

endmodule

// File: tb/tb_sdram_avalon_arbiter.sv
// Directed bench for sdram_avalon_arbiter with a small SDRAM slave model
// returning read data a fixed three cycles after acceptance.
module tb_sdram_avalon_arbiter;
    logic       clk;
    logic       rst;
    logic [1:0] grant;
    logic [2:0] pending;
    logic       error;

    int n_checks = 0;
    int n_pass   = 0;
    int bus_bad  = 0;
    int rd_data_bad = 0;
    int n_rd     = 0;

    bit         auto_ret     = 1'b0;
    bit         manual_valid = 1'b0;
    bit         log_en       = 1'b0;
    bit         last_rd_acc  = 1'b0;
    bit         last_wr_acc  = 1'b0;
    logic [2:0] vpipe;
    logic [15:0] dpipe [3];
    byte        ev_q [$];

    sdram_avalon_arbiter_if #(.ADDR_W(25), .DATA_W(16)) bus ();

    sdram_avalon_arbiter #(
        .ADDR_W(25), .DATA_W(16), .MAX_RD_BURST(8), .MAX_WR_BURST(4), .MAX_PENDING(7)
    ) dut (
        .iCLK     (clk),
        .iRST     (rst),
        .bus      (bus),
        .oGRANT   (grant),
        .oPENDING (pending),
        .oERROR   (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample handshakes before the edge, then update masters and slave model.
    task automatic step();
        logic acc_r, acc_w;
        #1;
        acc_r = bus.oSDRAM_RD & ~bus.iSDRAM_WAIT;
        acc_w = bus.oSDRAM_WR & ~bus.iSDRAM_WAIT;
        if (acc_r && (bus.oSDRAM_ADDR !== bus.iRD_ADDR)) bus_bad++;
        if (acc_w && ((bus.oSDRAM_ADDR !== bus.iWR_ADDR) || (bus.oSDRAM_WRDATA !== bus.iWR_DATA))) bus_bad++;
        if (vpipe[2] && ((bus.oRD_DATAVALID !== 1'b1) || (bus.oRD_DATA !== dpipe[2]))) rd_data_bad++;
        @(posedge clk);
        @(negedge clk);
        dpipe[2] = dpipe[1];
        dpipe[1] = dpipe[0];
        dpipe[0] = bus.iRD_ADDR[15:0] ^ 16'hA5A5;
        vpipe = rst ? 3'b000 : {vpipe[1:0], acc_r & auto_ret};
        bus.iSDRAM_RDDATAVALID = vpipe[2] | manual_valid;
        bus.iSDRAM_RDDATA      = vpipe[2] ? dpipe[2] : 16'h0000;
        if (acc_r) begin
            bus.iRD_ADDR = bus.iRD_ADDR + 25'd1;
            n_rd++;
        end
        if (acc_w) begin
            bus.iWR_ADDR = bus.iWR_ADDR + 25'd1;
            bus.iWR_DATA = bus.iWR_DATA + 16'h0101;
        end
        if (log_en && acc_r) ev_q.push_back(8'd82);
        if (log_en && acc_w) ev_q.push_back(8'd87);
        last_rd_acc = acc_r;
        last_wr_acc = acc_w;
        #1;
    endtask

    initial begin
        int         rd0;
        int         bad;
        logic [2:0] peak;
        byte        exp_ev;

        rst = 1'b1;
        bus.iRD_REQ = 1'b0;  bus.iRD_ADDR = 25'h100;
        bus.iWR_REQ = 1'b0;  bus.iWR_ADDR = 25'h8000;  bus.iWR_DATA = 16'h1234;
        bus.iSDRAM_WAIT = 1'b0;  bus.iSDRAM_RDDATA = 16'h0000;  bus.iSDRAM_RDDATAVALID = 1'b0;
        vpipe = 3'b000;
        for (int i = 0; i < 3; i++) dpipe[i] = 16'h0000;
        @(negedge clk);
        step();
        step();
        check_eq("rst_grant", 32'(grant), 32'd0);
        check_eq("rst_pending", 32'(pending), 32'd0);
        check_eq("rst_error", 32'(error), 32'd0);
        check_eq("rst_sdram_rd", 32'(bus.oSDRAM_RD), 32'd0);
        check_eq("rst_sdram_wr", 32'(bus.oSDRAM_WR), 32'd0);
        check_eq("rst_rd_wait", 32'(bus.oRD_WAIT), 32'd1);
        check_eq("rst_wr_wait", 32'(bus.oWR_WAIT), 32'd1);
        rst = 1'b0;

        // 1: read-only stream of 20 with 3-cycle return latency
        auto_ret = 1'b1;
        bus.iRD_REQ = 1'b1;
        step();
        rd0 = n_rd; peak = 3'd0; bad = 0;
        for (int c = 0; c < 60 && (n_rd - rd0) < 20; c++) begin
            if (grant !== 2'b01) bad++;
            if (pending > peak) peak = pending;
            step();
        end
        bus.iRD_REQ = 1'b0;
        for (int c = 0; c < 6; c++) step();
        check_eq("t1_reads_accepted", 32'(n_rd - rd0), 32'd20);
        check_eq("t1_grant_bad", 32'(bad), 32'd0);
        check_eq("t1_pending_peak", 32'(peak), 32'd3);
        check_eq("t1_pending_drained", 32'(pending), 32'd0);
        check_eq("t1_error", 32'(error), 32'd0);
        check_eq("t1_idle_after", 32'(grant), 32'd0);

        // 2: both masters busy -> 8 reads then 4 writes, reads first
        bus.iRD_REQ = 1'b1;
        bus.iWR_REQ = 1'b1;
        step();
        check_eq("t2_first_grant", 32'(grant), 32'd1);
        log_en = 1'b1;
        for (int c = 0; c < 80 && ev_q.size() < 36; c++) step();
        log_en = 1'b0;
        check_eq("t2_event_count", 32'(ev_q.size() >= 36), 32'd1);
        bad = 0;
        for (int i = 0; i < 36 && i < ev_q.size(); i++) begin
            exp_ev = ((i % 12) < 8) ? 8'd82 : 8'd87;
            if (ev_q[i] != exp_ev) bad++;
        end
        check_eq("t2_pattern_bad", 32'(bad), 32'd0);
        bus.iRD_REQ = 1'b0;
        bus.iWR_REQ = 1'b0;
        for (int c = 0; c < 6; c++) step();
        check_eq("t2_pending_drained", 32'(pending), 32'd0);

        // 3: slave stalls a read for 5 cycles while a write request arrives
        bus.iRD_REQ = 1'b1;
        step();
        bus.iSDRAM_WAIT = 1'b1;
        bus.iWR_REQ = 1'b1;
        #1;
        bad = 0;
        for (int c = 0; c < 5; c++) begin
            if ((grant !== 2'b01) || (bus.oWR_WAIT !== 1'b1) || (bus.oRD_WAIT !== 1'b1) || (bus.oSDRAM_RD !== 1'b1)) bad++;
            step();
        end
        check_eq("t3_stall_bad", 32'(bad), 32'd0);
        bus.iSDRAM_WAIT = 1'b0;
        #1;
        check_eq("t3_grant_held", 32'(grant), 32'd1);
        check_eq("t3_wr_wait", 32'(bus.oWR_WAIT), 32'd1);
        check_eq("t3_rd_wait_released", 32'(bus.oRD_WAIT), 32'd0);
        step();
        check_eq("t3_read_accepted", 32'(last_rd_acc), 32'd1);
        bus.iRD_REQ = 1'b0;
        #1;
        check_eq("t3_grant_still_rd", 32'(grant), 32'd1);
        step();
        check_eq("t3_grant_wr", 32'(grant), 32'd2);
        check_eq("t3_wr_wait_granted", 32'(bus.oWR_WAIT), 32'd0);
        bus.iWR_REQ = 1'b0;
        for (int c = 0; c < 6; c++) step();

        // 4: read data withheld -> pending saturates at 7
        auto_ret = 1'b0;
        bus.iRD_REQ = 1'b1;
        step();
        rd0 = n_rd;
        for (int c = 0; c < 20 && (n_rd - rd0) < 7; c++) step();
        check_eq("t4_pending_full", 32'(pending), 32'd7);
        check_eq("t4_rd_wait_full", 32'(bus.oRD_WAIT), 32'd1);
        check_eq("t4_sdram_rd_blocked", 32'(bus.oSDRAM_RD), 32'd0);
        step();
        step();
        check_eq("t4_no_issue_when_full", 32'(n_rd - rd0), 32'd7);
        bus.iSDRAM_RDDATAVALID = 1'b1;
        step();
        check_eq("t4_pending_after_ret", 32'(pending), 32'd6);
        check_eq("t4_sdram_rd_resumes", 32'(bus.oSDRAM_RD), 32'd1);
        check_eq("t4_rd_wait_resumes", 32'(bus.oRD_WAIT), 32'd0);
        step();
        check_eq("t4_reissued", 32'(last_rd_acc), 32'd1);
        check_eq("t4_pending_refull", 32'(pending), 32'd7);
        bus.iRD_REQ = 1'b0;
        bus.iSDRAM_RDDATAVALID = 1'b1;
        manual_valid = 1'b1;
        for (int i = 0; i < 7; i++) begin
            if (i == 6) manual_valid = 1'b0;
            step();
        end
        check_eq("t4_pending_drained", 32'(pending), 32'd0);
        check_eq("t4_error", 32'(error), 32'd0);

        // 5: stray readdatavalid with nothing outstanding
        bus.iSDRAM_RDDATAVALID = 1'b1;
        step();
        check_eq("t5_error_set", 32'(error), 32'd1);
        check_eq("t5_pending_zero", 32'(pending), 32'd0);
        step(); step(); step();
        check_eq("t5_error_sticky", 32'(error), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("t5_error_cleared", 32'(error), 32'd0);

        // 6: reset in the middle of a write burst with 2 reads outstanding
        bus.iRD_REQ = 1'b1;
        step(); step(); step();
        check_eq("t6_pending_two", 32'(pending), 32'd2);
        bus.iRD_REQ = 1'b0;
        bus.iWR_REQ = 1'b1;
        step();
        step();
        check_eq("t6_write_accepted", 32'(last_wr_acc), 32'd1);
        check_eq("t6_grant_wr", 32'(grant), 32'd2);
        rst = 1'b1;
        step();
        check_eq("t6_grant", 32'(grant), 32'd0);
        check_eq("t6_pending", 32'(pending), 32'd0);
        check_eq("t6_sdram_wr", 32'(bus.oSDRAM_WR), 32'd0);
        check_eq("t6_rd_wait", 32'(bus.oRD_WAIT), 32'd1);
        check_eq("t6_wr_wait", 32'(bus.oWR_WAIT), 32'd1);
        rst = 1'b0;
        bus.iWR_REQ = 1'b0;
        step();

        check_eq("bus_addr_data_bad", 32'(bus_bad), 32'd0);
        check_eq("rd_data_bad", 32'(rd_data_bad), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
